stim_vector_player: RTL and testbench

//  Drives the primary inputs of a gate-level circuit under simulation (and/or gate

---
 rtl/stim_vector_player.sv | 154 +++++++++++++++
 tb/tb_stim_vector_player.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stim_vector_player.sv
// rtl/stim_vector_player.sv - vector table player: applies stimulus, waits settle window, checks outputs
module stim_vector_player #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 1,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [N_IN-1:0]  wr_stim,
    input  logic [N_OUT-1:0] wr_exp,
    input  logic [CW-1:0]    num_vec,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    err_cnt,
    output logic [AW-1:0]    first_fail
);

    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNTW-1:0] SETTLE_M1 = CNTW'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_WAIT,
        S_SAMPLE,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic              pass_q, pass_d;
    logic [CW-1:0]     err_q, err_d;
    logic [AW-1:0]     ff_q, ff_d;
    logic              mismatch;

    logic [N_IN-1:0]   tbl_stim [DEPTH];
    logic [N_OUT-1:0]  tbl_exp  [DEPTH];

    // Table has no reset so contents survive an aborted run
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            tbl_stim[wr_addr] <= wr_stim;
            tbl_exp[wr_addr]  <= wr_exp;
        end
    end

    assign mismatch = (dut_out != tbl_exp[idx_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        stim_d  = stim_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ff_d    = ff_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = '0;
                    ff_d  = '0;
                    if (num_vec != '0) begin
                        n_d     = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
                        idx_d   = '0;
                        pass_d  = 1'b0;
                        state_d = S_APPLY;
                    end else begin
                        pass_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_APPLY: begin
                stim_d  = tbl_stim[idx_q];
                cnt_d   = SETTLE_M1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (err_q == '0) begin
                        ff_d = idx_q;
                    end
                end
                if (CW'(idx_q) == n_q - CW'(1)) begin
                    // pass is settled on entry to FIN so it is valid alongside done
                    pass_d  = (err_d == '0);
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_APPLY;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            stim_q  <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            stim_q  <= stim_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
        end
    end

    assign stim       = stim_q;
    assign busy       = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_SAMPLE);
    assign done       = (state_q == S_FIN);
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_stim_vector_player.sv
// tb/tb_stim_vector_player.sv - self-checking bench for stim_vector_player
module tb_stim_vector_player;

    localparam int DEPTH  = 16;
    localparam int SETTLE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_stim;
    logic [0:0] wr_exp;
    logic [4:0] num_vec;
    logic       start;
    logic [3:0] stim;
    logic [0:0] dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_cnt;
    logic [3:0] first_fail;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] m_stim [DEPTH];
    logic       m_exp  [DEPTH];
    logic       resp_lut [16];
    logic       use_lut = 1'b0;

    typedef struct {
        int addr; int s; int e; int num;
        int err; int ff; int ps; int n;
    } rec_t;
    rec_t recs[8];

    always #5 clk = ~clk;

    assign dut_out = use_lut ? resp_lut[stim] : (stim[1] & stim[0]);

    stim_vector_player dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_stim(wr_stim), .wr_exp(wr_exp), .num_vec(num_vec), .start(start),
        .stim(stim), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail(first_fail)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic resp(input logic [3:0] s);
        return use_lut ? resp_lut[s] : (s[1] & s[0]);
    endfunction

    function automatic void model(input int num, output int err, output int ff,
                                  output int ps, output int n);
        n   = (num > DEPTH) ? DEPTH : num;
        err = 0;
        ff  = 0;
        for (int i = 0; i < n; i++) begin
            if (resp(m_stim[i]) != m_exp[i]) begin
                if (err == 0) ff = i;
                err++;
            end
        end
        ps = (err == 0) ? 1 : 0;
    endfunction

    task automatic write_vec(input int a, input int s, input int e);
        wr_en   = 1'b1;
        wr_addr = a[3:0];
        wr_stim = s[3:0];
        wr_exp  = e[0:0];
        @(posedge clk); #1;
        wr_en   = 1'b0;
        m_stim[a] = s[3:0];
        m_exp[a]  = e[0];
    endtask

    task automatic run_check(input string tag, input int num, input int exp_err,
                             input int exp_ff, input int exp_pass, input int exp_n);
        int  c;
        bit  saw_busy;
        num_vec = num[4:0];
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        c = 0;
        saw_busy = 0;
        if (exp_n > 0) check({tag, "_busy_rise"}, busy, 1);
        while (!done && c < 2000) begin
            if (busy) saw_busy = 1;
            @(posedge clk); #1;
            c++;
        end
        check({tag, "_done_cycle"}, c, exp_n * (SETTLE + 2));
        check({tag, "_busy_seen"}, saw_busy, (exp_n > 0) ? 1 : 0);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_err_cnt"}, err_cnt, exp_err);
        check({tag, "_first_fail"}, first_fail, exp_ff);
        check({tag, "_pass"}, pass, exp_pass);
        if (exp_n > 0) check({tag, "_stim_hold"}, stim, m_stim[exp_n-1]);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_pass_hold"}, pass, exp_pass);
    endtask

    initial begin
        int e_err, e_ff, e_ps, e_n, dcnt, nv;

        recs[0] = '{3, 3, 1, 4, 0, 0, 1, 4};
        recs[1] = '{2, 2, 1, 4, 1, 2, 0, 4};
        recs[2] = '{2, 2, 0, 0, 0, 0, 1, 0};
        recs[3] = '{0, 0, 0, 3, 0, 0, 1, 3};
        recs[4] = '{1, 1, 1, 2, 1, 1, 0, 2};
        recs[5] = '{0, 0, 1, 4, 2, 0, 0, 4};
        recs[6] = '{0, 0, 0, 4, 1, 1, 0, 4};
        recs[7] = '{1, 1, 0, 4, 0, 0, 1, 4};

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_stim = '0; wr_exp = '0;
        num_vec = '0; start = 1'b0;
        for (int i = 0; i < 16; i++) resp_lut[i] = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_cnt, 0);
        check("rst_ff", first_fail, 0);
        check("rst_stim", stim, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        write_vec(0, 0, 0);
        write_vec(1, 1, 0);
        write_vec(2, 2, 0);
        write_vec(3, 3, 1);

        for (int r = 0; r < 8; r++) begin
            write_vec(recs[r].addr, recs[r].s, recs[r].e);
            run_check($sformatf("rec%0d", r), recs[r].num, recs[r].err,
                      recs[r].ff, recs[r].ps, recs[r].n);
        end

        // reset during WAIT of vector 1
        num_vec = 5'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_stim", stim, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dcnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("mid_rst_no_done", dcnt, 0);
        run_check("restart", 4, 0, 0, 1, 4);

        // write and start while busy are ignored
        fork
            run_check("busy_ignore", 4, 0, 0, 1, 4);
            begin
                repeat (5) @(posedge clk);
                #3;
                wr_en = 1'b1; wr_addr = 4'd3; wr_stim = 4'd3; wr_exp = 1'b0; start = 1'b1;
                @(posedge clk); #3;
                wr_en = 1'b0; start = 1'b0;
            end
        join
        dcnt = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("busy_ignore_single_done", dcnt, 0);
        run_check("table_intact", 4, 0, 0, 1, 4);

        // write and start in the same IDLE cycle
        wr_en = 1'b1; wr_addr = 4'd0; wr_stim = 4'd3; wr_exp = 1'b1;
        m_stim[0] = 4'd3; m_exp[0] = 1'b1;
        run_check("wr_and_start", 1, 0, 0, 1, 1);

        // randomized table and response checked against the model
        use_lut = 1'b1;
        for (int i = 0; i < 16; i++) resp_lut[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < DEPTH; i++)
            write_vec(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
        for (int t = 0; t < 8; t++) begin
            if (t == 0) nv = 31;
            else if (t == 1) nv = 16;
            else if (t == 2) nv = 1;
            else nv = int'($urandom_range(0, 31));
            model(nv, e_err, e_ff, e_ps, e_n);
            run_check($sformatf("rand%0d_n%0d", t, nv), nv, e_err, e_ff, e_ps, e_n);
            write_vec(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
